// File: rtl/reg16_bypass.sv
// Word-wide storage register with write-through bypass; the state element of
// the program counter. A write is visible on dout in the same cycle it is presented.
module reg16_bypass #(
  parameter int unsigned           WIDTH       = 16,
  parameter logic [WIDTH-1:0]      RESET_VALUE = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             cs,
  input  logic             w,
  output logic [WIDTH-1:0] dout
);

  logic             we_s;
  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] dout_s;

  // Write enable: the strobe only counts while the block is selected.
  always_comb begin
    we_s = cs & w;
  end

  // Next-state for the storage; an unknown enable falls to the hold branch.
  always_comb begin
    q_d = q_q;
    if (we_s) begin
      q_d = din;
    end else begin
      q_d = q_q;
    end
  end

  // Storage flops with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= RESET_VALUE;
    end else begin
      q_q <= q_d;
    end
  end

  // Output select: reset value during reset, incoming word while writing,
  // otherwise the stored word.
  always_comb begin
    dout_s = q_q;
    if (!rst_n) begin
      dout_s = RESET_VALUE;
    end else if (we_s) begin
      dout_s = din;
    end else begin
      dout_s = q_q;
    end
  end

  assign dout = dout_s;

endmodule

// File: tb/tb_reg16_bypass.sv
// Self-checking bench for reg16_bypass: directed plan plus randomized traffic,
// checked against a behavioural model of the stored word.
module tb_reg16_bypass;

  logic        clk;
  logic        rst_n;
  logic [15:0] din;
  logic        cs;
  logic        w;
  logic [15:0] dout;

  int unsigned total;
  int unsigned bad;
  logic [15:0] q_m;
  logic        cmp_en;

  reg16_bypass #(.WIDTH(16), .RESET_VALUE(16'h0000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (din),
    .cs    (cs),
    .w     (w),
    .dout  (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] exp_dout();
    if (rst_n !== 1'b1) return 16'h0000;
    if (cs === 1'b1 && w === 1'b1) return din;
    return q_m;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: dout=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Model of the storage: reset clears it at once, a selected write edge loads din.
  always @(negedge rst_n) q_m = 16'h0000;
  always @(posedge clk) begin
    if (rst_n !== 1'b1) q_m = 16'h0000;
    else if (cs === 1'b1 && w === 1'b1) q_m = din;
  end

  // Per-cycle comparison, half a period away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) chk("cycle", dout, exp_dout());
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic set_in(input logic c, input logic ww, input logic [15:0] d);
    cs = c; w = ww; din = d;
  endtask

  initial begin
    total = 0; bad = 0; cmp_en = 1'b1;
    rst_n = 1'b0;
    set_in(1'b1, 1'b1, 16'hBEEF);
    #1 chk("reset_bypass_blocked", dout, 16'h0000);
    repeat (3) cyc();
    chk("reset_held", dout, 16'h0000);
    rst_n = 1'b1;
    set_in(1'b0, 1'b0, 16'hBEEF);
    cyc();
    chk("after_release", dout, 16'h0000);

    set_in(1'b1, 1'b1, 16'h1234);
    #1 chk("bypass_same_cycle", dout, 16'h1234);
    cyc();
    w = 1'b0;
    #1 chk("stored_1234", dout, 16'h1234);

    set_in(1'b0, 1'b1, 16'hFFFF);
    repeat (3) cyc();
    chk("cs_low_ignored", dout, 16'h1234);
    set_in(1'b1, 1'b0, 16'h0F0F);
    repeat (2) cyc();
    chk("w_low_hold", dout, 16'h1234);

    set_in(1'b1, 1'b1, 16'h0001);
    #1 chk("b2b_1", dout, 16'h0001);
    cyc(); din = 16'h0002;
    #1 chk("b2b_2", dout, 16'h0002);
    cyc(); din = 16'hFFFF;
    #1 chk("b2b_3", dout, 16'hFFFF);
    cyc(); w = 1'b0;
    #1 chk("b2b_stored", dout, 16'hFFFF);

    set_in(1'b1, 1'b1, 16'hA5A5);
    cyc(); w = 1'b0;
    #1 chk("stored_a5a5", dout, 16'hA5A5);
    rst_n = 1'b0;
    #1 chk("async_reset_now", dout, 16'h0000);
    #1 rst_n = 1'b1;
    #1 chk("after_pulse", dout, 16'h0000);
    cyc();
    chk("after_pulse_edge", dout, 16'h0000);

    // PC-style increment from reset, reading back with w low after each edge.
    for (int k = 1; k <= 4; k++) begin
      set_in(1'b1, 1'b1, 16'(k));
      cyc();
      w = 1'b0;
      #1 chk("pc_step", dout, 16'(k));
    end
    set_in(1'b1, 1'b1, 16'hFFFF);
    cyc();
    din = 16'h0000;
    cyc();
    w = 1'b0;
    #1 chk("pc_wrap", dout, 16'h0000);

    // Randomized traffic with occasional mid-cycle reset pulses.
    for (int i = 0; i < 400; i++) begin
      set_in(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom));
      if ($urandom_range(0, 39) == 0) begin
        rst_n = 1'b0;
        #1 chk("rand_async_reset", dout, 16'h0000);
        #1 rst_n = 1'b1;
      end
      cyc();
    end

    @(posedge clk);
    cmp_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
